io_bank: RTL and testbench
==========================

// Module: io_bank
// PURPOSE
//  Responder on the MMU I/O port (0x80000000-0x800000FF): decodes io_addr/io_en/io_we, returns io_data_read.
//  Holds ID, GPIO, a free-running timer with compare flag, and a byte TX FIFO drained by valid/ready.
//  Read data is combinational from the MMU's registered strobes, so the MMU samples it in the same cycle.
//  Writes commit on the clk edge.
// PARAMETERS
//  ID_VALUE     32'h10C0_0001  constant returned by the ID register
//  GPIO_W       8              width of gpio_out / gpio_in (1..32)
//  TX_DEPTH     4              TX FIFO depth in bytes, power of 2, >=2
//  TX_DEPTH_LOG 2              log2(TX_DEPTH)
// PORTS
//  clk            in   1        clock, all state on posedge
//  reset          in   1        asynchronous, active-high reset
//  io_addr        in   8        byte address within I/O window; [7:2] decoded, [1:0] ignored
//  io_en          in   1        access strobe, one cycle per access
//  io_we          in   1        1 = write, 0 = read (qualified by io_en)
//  io_data_write  in   32       write data (byte stores arrive on lanes per dm_be; registers use [7:0] or full word)
//  io_data_read   out  32       read data, combinational
//  gpio_out       out  GPIO_W   GPIO output register
//  gpio_in        in   GPIO_W   asynchronous GPIO inputs
//  timer_irq      out  1        timer match flag
//  tx_data        out  8        FIFO head byte
//  tx_valid       out  1        FIFO not empty
//  tx_ready       in   1        consumer accepts tx_data when tx_valid && tx_ready
// BEHAVIOUR
//  Register map (io_addr[7:2]); unmapped reads return 0; unmapped writes are ignored:
//   0x00 ID        RO  ID_VALUE
//   0x04 GPIO_OUT  RW  [GPIO_W-1:0]; upper bits read 0
//   0x08 GPIO_IN   RO  gpio_in through 2-flop synchronizer (2-cycle latency)
//   0x0C TIMER     RW  32-bit counter; a write loads io_data_write, which beats the increment that cycle
//   0x10 TIMER_CMP RW  32-bit compare value
//   0x14 STATUS    bit0 match (W1C), bit1 tx_full, bit2 tx_empty, bit3 tx_overflow (W1C),
//                  [11:8] tx_count (zero-extended); other bits 0; writes to bits 1,2,[11:8] ignored
//   0x18 TX_DATA   WO  push io_data_write[7:0]; reads return 0
//  - io_data_read = io_en && !io_we ? selected register : 32'h0. Reads have no side effects.
//  - Write occurs at the posedge where io_en && io_we.
//  - Timer: +1 every cycle, wraps 32'hFFFFFFFF -> 0.
//    When the TIMER value equals TIMER_CMP during a cycle, match is set at the next edge.
//    timer_irq = match.
//  - Match set and a W1C clear in the same cycle: set wins.
//    Overflow set and a W1C clear in the same cycle: set wins.
//  - FIFO: circular buffer with rd/wr pointers of TX_DEPTH_LOG bits plus count of TX_DEPTH_LOG+1 bits.
//    tx_data = mem[rd]; tx_valid = (count != 0).
//  - Pop: at the edge where tx_valid && tx_ready. Push: TX_DATA write.
//    A push is accepted if count < TX_DEPTH or a pop happens in the same cycle.
//    Push and pop together leave count unchanged.
//  - A rejected push drops the byte, sets tx_overflow, and leaves FIFO contents and pointers unchanged.
//  - Pointers wrap modulo TX_DEPTH. tx_data must stay stable while tx_valid && !tx_ready.
//  - Reset (any time, including mid-drain) clears:
//    gpio_out, synchronizer flops, TIMER, match and overflow to 0; TIMER_CMP to 32'hFFFFFFFF; FIFO pointers/count to 0.
//    Outputs under reset: tx_valid=0, timer_irq=0, gpio_out=0, tx_data=mem[0] (don't-care).
//    FIFO memory is not reset.
// TESTING
//  1. Read 0x00 with io_en=1, io_we=0 -> io_data_read=32'h10C00001; with io_en=0 -> 0.
//  2. Write 0x04=0xA5, read 0x04 -> 0x000000A5 and gpio_out=8'hA5. Set gpio_in=8'h3C -> GPIO_IN reads 0x3C two cycles later, not before.
//  3. Write TIMER_CMP=10, TIMER=5 -> timer_irq rises 6 cycles after the write edge. W1C STATUS=1 -> clears.
//     Clear issued in the same cycle as a new match -> irq stays 1.
//  4. tx_ready=0; push 0x11,0x22,0x33,0x44 -> STATUS: tx_full=1, count=4.
//     5th push 0x55 -> dropped, overflow=1. tx_ready=1 -> bytes 11,22,33,44 in order, then tx_valid=0, tx_empty=1.
//  5. FIFO full with tx_ready=1 and a push of 0x66 in the same cycle -> accepted, count stays 4, no overflow.
//     Keep streaming 10 bytes -> order preserved across pointer wrap.
//  6. Assert reset mid-drain with count=3, gpio_out=0xFF, timer running -> immediately tx_valid=0, gpio_out=0, TIMER reads 0.
//     After release the timer restarts from 0.

Source files
------------

// File: rtl/io_bank.sv
// io_bank: MMU I/O-window responder with ID, GPIO, timer/compare and a byte TX FIFO.
// Read data is combinational from the strobes; all writes commit on the clock edge.
module io_bank #(
    parameter logic [31:0] ID_VALUE     = 32'h10C0_0001,
    parameter int          GPIO_W       = 8,
    parameter int          TX_DEPTH     = 4,
    parameter int          TX_DEPTH_LOG = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        io_addr,
    input  logic              io_en,
    input  logic              io_we,
    input  logic [31:0]       io_data_write,
    output logic [31:0]       io_data_read,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              timer_irq,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);
    localparam logic [5:0] A_ID  = 6'h00;
    localparam logic [5:0] A_GPO = 6'h01;
    localparam logic [5:0] A_GPI = 6'h02;
    localparam logic [5:0] A_TMR = 6'h03;
    localparam logic [5:0] A_CMP = 6'h04;
    localparam logic [5:0] A_STS = 6'h05;
    localparam logic [5:0] A_TXD = 6'h06;

    logic [GPIO_W-1:0]       r_gpio_out;
    logic [GPIO_W-1:0]       r_sync1;
    logic [GPIO_W-1:0]       r_sync2;
    logic [31:0]             r_timer;
    logic [31:0]             r_cmp;
    logic                    r_match;
    logic                    r_ovf;
    logic [7:0]              r_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG-1:0] r_rd;
    logic [TX_DEPTH_LOG-1:0] r_wr;
    logic [TX_DEPTH_LOG:0]   r_cnt;

    logic [5:0]  w_sel;
    logic        w_wr;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_push_ok;
    logic        w_sts_wr;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel     = io_addr[7:2];
    assign w_unused  = ^io_addr[1:0];
    assign w_wr      = io_en && io_we;
    // count never exceeds TX_DEPTH, so its top bit alone marks full
    assign w_full    = r_cnt[TX_DEPTH_LOG];
    assign w_empty   = (r_cnt == '0);
    assign w_pop     = tx_valid && tx_ready;
    assign w_push    = w_wr && (w_sel == A_TXD);
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_sts_wr  = w_wr && (w_sel == A_STS);
    assign w_status  = {20'h0, 4'(r_cnt), 4'h0, r_ovf, w_empty, w_full, r_match};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_timer    <= '0;
            r_cmp      <= '1;
            r_match    <= 1'b0;
            r_ovf      <= 1'b0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_wr && (w_sel == A_GPO))
                r_gpio_out <= io_data_write[GPIO_W-1:0];
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            r_timer <= (w_wr && (w_sel == A_TMR)) ? io_data_write : r_timer + 32'd1;
            if (w_wr && (w_sel == A_CMP))
                r_cmp <= io_data_write;
            // sticky flags: a new event outranks a same-cycle W1C clear
            r_match <= (r_timer == r_cmp) || (r_match && !(w_sts_wr && io_data_write[0]));
            r_ovf   <= (w_push && !w_push_ok) || (r_ovf && !(w_sts_wr && io_data_write[3]));
            if (w_push_ok)
                r_wr <= r_wr + TX_DEPTH_LOG'(1);
            if (w_pop)
                r_rd <= r_rd + TX_DEPTH_LOG'(1);
            if (w_push_ok != w_pop)
                r_cnt <= w_push_ok ? r_cnt + (TX_DEPTH_LOG+1)'(1) : r_cnt - (TX_DEPTH_LOG+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr] <= io_data_write[7:0];
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            A_ID:    w_rdata = ID_VALUE;
            A_GPO:   w_rdata = 32'(r_gpio_out);
            A_GPI:   w_rdata = 32'(r_sync2);
            A_TMR:   w_rdata = r_timer;
            A_CMP:   w_rdata = r_cmp;
            A_STS:   w_rdata = w_status;
            default: w_rdata = '0;
        endcase
    end

    assign io_data_read = (io_en && !io_we) ? w_rdata : 32'h0;
    assign gpio_out     = r_gpio_out;
    assign timer_irq    = r_match;
    assign tx_data      = r_mem[r_rd];
    assign tx_valid     = !w_empty;
endmodule

// File: tb/tb_io_bank.sv
// tb_io_bank: directed register, timer, FIFO and reset checks for io_bank.
module tb_io_bank;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  io_addr = '0;
    logic        io_en = 1'b0;
    logic        io_we = 1'b0;
    logic [31:0] io_data_write = '0;
    logic [31:0] io_data_read;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_in = '0;
    logic        timer_irq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  q[$];

    io_bank dut (
        .clk(clk), .reset(reset), .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
        .io_data_write(io_data_write), .io_data_read(io_data_read), .gpio_out(gpio_out),
        .gpio_in(gpio_in), .timer_irq(timer_irq), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic rchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        io_addr = a;
        io_en = 1'b1;
        io_we = 1'b0;
        #1;
        chk(tag, io_data_read, exp);
        io_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        io_addr = a;
        io_data_write = d;
        io_en = 1'b1;
        io_we = 1'b1;
        @(negedge clk);
        io_en = 1'b0;
        io_we = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        chk("rst_gpio_out", 32'(gpio_out), 32'h0);
        rchk("rst_cmp", 8'h10, 32'hFFFF_FFFF);
        rchk("rst_status", 8'h14, 32'h4);
        reset = 1'b0;
        rchk("id", 8'h00, 32'h10C0_0001);
        rchk("id_byte_offset", 8'h03, 32'h10C0_0001);
        io_addr = 8'h00;
        #1;
        chk("id_no_en", io_data_read, 32'h0);
        rchk("unmapped", 8'h40, 32'h0);
        wr(8'h40, 32'hDEAD_BEEF);
        wr(8'h04, 32'h1234_56A5);
        rchk("gpio_out_rd", 8'h04, 32'hA5);
        chk("gpio_out_pin", 32'(gpio_out), 32'hA5);
        gpio_in = 8'h3C;
        rchk("gpio_in_0", 8'h08, 32'h0);
        @(negedge clk);
        rchk("gpio_in_1", 8'h08, 32'h0);
        @(negedge clk);
        rchk("gpio_in_2", 8'h08, 32'h3C);
        wr(8'h0C, 32'h100);
        wr(8'h10, 32'd10);
        wr(8'h0C, 32'd5);
        rchk("timer_load", 8'h0C, 32'd5);
        repeat (5) @(negedge clk);
        chk("irq_before", 32'(timer_irq), 32'h0);
        @(negedge clk);
        chk("irq_rise", 32'(timer_irq), 32'h1);
        rchk("status_match", 8'h14, 32'h5);
        wr(8'h14, 32'h1);
        chk("irq_w1c", 32'(timer_irq), 32'h0);
        wr(8'h0C, 32'd9);
        @(negedge clk);
        chk("irq_pre_race", 32'(timer_irq), 32'h0);
        wr(8'h14, 32'h1);
        chk("irq_set_wins", 32'(timer_irq), 32'h1);
        wr(8'h14, 32'h1);
        chk("irq_clear2", 32'(timer_irq), 32'h0);
        wr(8'h0C, 32'hFFFF_FFFF);
        @(negedge clk);
        rchk("timer_wrap", 8'h0C, 32'h0);
        wr(8'h10, 32'hFFFF_FFFF);
        wr(8'h14, 32'h1);
        wr(8'h18, 32'h11);
        chk("tx_first", {23'h0, tx_valid, tx_data}, 32'h111);
        wr(8'h18, 32'h22);
        wr(8'h18, 32'h33);
        wr(8'h18, 32'h44);
        rchk("status_full", 8'h14, 32'h402);
        wr(8'h18, 32'hABCD_EF55);
        rchk("status_ovf", 8'h14, 32'h40A);
        rchk("txdata_rd0", 8'h18, 32'h0);
        wr(8'h14, 32'hFFFF_FFF6);
        rchk("status_ro_bits", 8'h14, 32'h40A);
        wr(8'h14, 32'h8);
        rchk("ovf_w1c", 8'h14, 32'h402);
        chk("tx_stable", 32'(tx_data), 32'h11);
        tx_ready = 1'b1;
        chk("drain0", 32'(tx_data), 32'h11);
        @(negedge clk);
        chk("drain1", 32'(tx_data), 32'h22);
        @(negedge clk);
        chk("drain2", 32'(tx_data), 32'h33);
        @(negedge clk);
        chk("drain3", 32'(tx_data), 32'h44);
        @(negedge clk);
        chk("drain_done", 32'(tx_valid), 32'h0);
        rchk("status_empty", 8'h14, 32'h4);
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'h18, 32'(8'h61 + i));
        tx_ready = 1'b1;
        wr(8'h18, 32'h66);
        tx_ready = 1'b0;
        rchk("full_pushpop", 8'h14, 32'h402);
        chk("full_pushpop_head", 32'(tx_data), 32'h62);
        q = '{8'h62, 8'h63, 8'h64, 8'h66};
        for (int i = 0; i < 10; i++) begin
            tx_ready = 1'b1;
            chk("stream", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, q[0]});
            void'(q.pop_front());
            q.push_back(8'h70 + 8'(i));
            wr(8'h18, 32'(8'h70 + 8'(i)));
        end
        rchk("stream_status", 8'h14, 32'h402);
        for (int i = 0; i < 4; i++) begin
            chk("stream_tail", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, q[0]});
            void'(q.pop_front());
            @(negedge clk);
        end
        chk("stream_empty", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;
        wr(8'h04, 32'hFF);
        for (int i = 0; i < 4; i++) wr(8'h18, 32'(8'h81 + i));
        tx_ready = 1'b1;
        @(negedge clk);
        rchk("mid_drain", 8'h14, 32'h300);
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(tx_valid), 32'h0);
        chk("rst_mid_gpio", 32'(gpio_out), 32'h0);
        rchk("rst_mid_timer", 8'h0C, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rchk("timer_restart1", 8'h0C, 32'h1);
        @(negedge clk);
        rchk("timer_restart2", 8'h0C, 32'h2);
        rchk("post_rst_status", 8'h14, 32'h4);
        rchk("post_rst_cmp", 8'h10, 32'hFFFF_FFFF);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
